stack_regfile: RTL and testbench

STACK_REGFILE -- requirements
Module: stack_regfile

---
 rtl/stack_pkg.sv | 15 +
 rtl/stack_mem.sv | 29 ++
 rtl/stack_regfile.sv | 114 +++++++++++
 tb/tb_stack_regfile.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared defaults, pointer width helper and fault type codes for stack_regfile
package stack_pkg;

  localparam int STACK_DATA_W = 32;
  localparam int STACK_DEPTH  = 16;

  // err_ovf encoding: which kind of fault was the most recent one
  localparam logic ERR_UNDERFLOW = 1'b0;
  localparam logic ERR_OVERFLOW  = 1'b1;

  function automatic int sp_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stack_mem.sv
// rtl/stack_mem.sv - DEPTH x DATA_W storage, two async read ports, one sync write port, no reset
module stack_mem
  import stack_pkg::*;
#(
  parameter int DATA_W = STACK_DATA_W,
  parameter int DEPTH  = STACK_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  input  logic [$clog2(DEPTH)-1:0] raddr2,
  output logic [DATA_W-1:0]        rdata1,
  output logic [DATA_W-1:0]        rdata2
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/stack_regfile.sv
// rtl/stack_regfile.sv - operand stack register file; STACK_GUARD_EN enables overflow/underflow suppression
module stack_regfile
  import stack_pkg::*;
#(
  parameter int DATA_W = STACK_DATA_W,
  parameter int DEPTH  = STACK_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   read_reg1,
  input  logic                   read_reg2,
  input  logic                   write_reg,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rd1,
  output logic [DATA_W-1:0]      rd2,
  output logic [$clog2(DEPTH):0] sp,
  output logic                   full,
  output logic                   empty,
  output logic                   err,
  output logic                   err_ovf
);

  localparam int SP_W = sp_width(DEPTH);
  localparam int A_W  = $clog2(DEPTH);

  logic [SP_W-1:0]   sp_q;
  logic [SP_W-1:0]   npop;
  logic [SP_W-1:0]   sp_base;
  logic [SP_W-1:0]   sp_next;
  logic [A_W-1:0]    raddr1;
  logic [A_W-1:0]    raddr2;
  logic [A_W-1:0]    waddr;
  logic [DATA_W-1:0] mem_rd1;
  logic [DATA_W-1:0] mem_rd2;
  logic              fault;
  logic              we;

  assign npop    = SP_W'(read_reg1) + SP_W'(read_reg2);
  assign sp_base = sp_q - npop;
  assign sp_next = sp_base + SP_W'(write_reg);

  // The pushed value lands in the lowest slot freed by this cycle's pops
  assign raddr1 = A_W'(sp_q - SP_W'(1));
  assign raddr2 = A_W'(sp_q - SP_W'(2));
  assign waddr  = A_W'(sp_base);

  // rst_n gates the write so a reset held across an edge drops the push too
  assign we = en & write_reg & ~fault & rst_n;

  stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk    (clk),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (mem_rd1),
    .rdata2 (mem_rd2)
  );

`ifdef STACK_GUARD_EN
  logic unf;
  logic ovf;
  logic err_q;
  logic err_ovf_q;

  // Underflow wraps sp_next, so overflow is only meaningful when unf is clear
  assign unf   = npop > sp_q;
  assign ovf   = ~unf & (sp_next > SP_W'(DEPTH));
  assign fault = unf | ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q      <= '0;
      err_q     <= 1'b0;
      err_ovf_q <= ERR_UNDERFLOW;
    end else if (en) begin
      if (fault) begin
        err_q     <= 1'b1;
        err_ovf_q <= ovf ? ERR_OVERFLOW : ERR_UNDERFLOW;
      end else begin
        sp_q <= sp_next;
      end
    end
  end

  assign err     = err_q;
  assign err_ovf = err_ovf_q;
`else
  assign fault = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
    end else if (en) begin
      sp_q <= sp_next;
    end
  end

  assign err     = 1'b0;
  assign err_ovf = 1'b0;
`endif

  assign sp    = sp_q;
  assign full  = (sp_q == SP_W'(DEPTH));
  assign empty = (sp_q == '0);
  assign rd1   = (sp_q >= SP_W'(1)) ? mem_rd1 : '0;
  assign rd2   = (sp_q >= SP_W'(2)) ? mem_rd2 : '0;

endmodule

// File: tb/tb_stack_regfile.sv
// tb/tb_stack_regfile.sv - self-checking bench for stack_regfile (DEPTH=8), both STACK_GUARD_EN builds
module tb_stack_regfile;

  localparam int DW = 32;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          read_reg1 = 1'b0;
  logic          read_reg2 = 1'b0;
  logic          write_reg = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic [3:0]    sp;
  logic          full;
  logic          empty;
  logic          err;
  logic          err_ovf;

  int vectors = 0;
  int miscompares = 0;

  // reference model: occupancy count plus slot contents indexed by position
  int        m_sp;
  logic [31:0] m_mem [D];
  bit        m_ok [D];
  bit        m_err;
  bit        m_ovf;

  stack_regfile #(.DATA_W(DW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .wdata(wdata), .rd1(rd1), .rd2(rd2), .sp(sp),
    .full(full), .empty(empty), .err(err), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  function automatic int wrap(input int x, input int m);
    return ((x % m) + m) % m;
  endfunction

  task automatic model_step(input bit r1, input bit r2, input bit w, input logic [31:0] d);
    int n;
    int after;
    n = int'(r1) + int'(r2);
    after = m_sp - n + int'(w);
`ifdef STACK_GUARD_EN
    if (n > m_sp) begin
      m_err = 1; m_ovf = 0;
      return;
    end
    if (after > D) begin
      m_err = 1; m_ovf = 1;
      return;
    end
`endif
    if (w) begin
      m_mem[wrap(m_sp - n, D)] = d;
      m_ok[wrap(m_sp - n, D)] = 1;
    end
    m_sp = wrap(after, 2 * D);
  endtask

  task automatic apply(input bit e, input bit r1, input bit r2, input bit w, input logic [31:0] d);
    en = e; read_reg1 = r1; read_reg2 = r2; write_reg = w; wdata = d;
    @(posedge clk);
    if (e) model_step(r1, r2, w, d);
    #1;
    en = 0; read_reg1 = 0; read_reg2 = 0; write_reg = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    m_sp = 0; m_err = 0; m_ovf = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    m_sp = 0; m_err = 0; m_ovf = 0;
    vectors++; if (sp !== 4'd0) begin miscompares++; $display("FAIL reset_sp: got %0d expected 0", sp); end
    vectors++; if (empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got empty=%b full=%b expected 1/0", empty, full); end
    vectors++; if (rd1 !== '0 || rd2 !== '0) begin miscompares++; $display("FAIL reset_rd: got %h/%h expected 0/0", rd1, rd2); end
    vectors++; if (err !== 1'b0 || err_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b/%b expected 0/0", err, err_ovf); end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_push_pair();
    do_reset();
    apply(1, 0, 0, 1, 32'd5);
    apply(1, 0, 0, 1, 32'd7);
    vectors++; if (sp !== 4'd2) begin miscompares++; $display("FAIL push_pair_sp: got %0d expected 2", sp); end
    vectors++; if (rd1 !== 32'd7 || rd2 !== 32'd5) begin miscompares++; $display("FAIL push_pair_rd: got %0d/%0d expected 7/5", rd1, rd2); end
    vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL push_pair_empty: got %b expected 0", empty); end
  endtask

  task automatic test_pop_push();
    apply(1, 1, 1, 1, 32'd12);
    vectors++; if (sp !== 4'd1) begin miscompares++; $display("FAIL pop_push_sp: got %0d expected 1", sp); end
    vectors++; if (rd1 !== 32'd12 || rd2 !== 32'd0) begin miscompares++; $display("FAIL pop_push_rd: got %0d/%0d expected 12/0", rd1, rd2); end
  endtask

  task automatic test_full_legal();
    do_reset();
    for (int i = 1; i <= 8; i++) apply(1, 0, 0, 1, i);
    apply(1, 1, 0, 1, 32'd42);
    vectors++; if (sp !== 4'd8 || rd1 !== 32'd42 || rd2 !== 32'd7) begin miscompares++; $display("FAIL full_poppush: got sp=%0d rd1=%0d rd2=%0d expected 8/42/7", sp, rd1, rd2); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL full_poppush_err: got %b expected 0", err); end
    apply(1, 1, 0, 0, 32'd0);
    vectors++; if (sp !== 4'd7 || rd1 !== 32'd7) begin miscompares++; $display("FAIL full_pop: got sp=%0d rd1=%0d expected 7/7", sp, rd1); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 8; i++) apply(1, 0, 0, 1, i);
    vectors++; if (full !== 1'b1 || sp !== 4'd8) begin miscompares++; $display("FAIL ovf_full: got full=%b sp=%0d expected 1/8", full, sp); end
    apply(1, 0, 0, 1, 32'd9);
`ifdef STACK_GUARD_EN
    vectors++; if (sp !== 4'd8 || rd1 !== 32'd8) begin miscompares++; $display("FAIL ovf_guard: got sp=%0d rd1=%0d expected 8/8", sp, rd1); end
    vectors++; if (err !== 1'b1 || err_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_guard_err: got %b/%b expected 1/1", err, err_ovf); end
`else
    vectors++; if (sp !== 4'd9 || rd1 !== 32'd9 || rd2 !== 32'd8) begin miscompares++; $display("FAIL ovf_wrap: got sp=%0d rd1=%0d rd2=%0d expected 9/9/8", sp, rd1, rd2); end
    vectors++; if (err !== 1'b0 || full !== 1'b0) begin miscompares++; $display("FAIL ovf_wrap_flags: got err=%b full=%b expected 0/0", err, full); end
`endif
  endtask

  task automatic test_underflow();
    do_reset();
    apply(1, 1, 0, 0, 32'd0);
`ifdef STACK_GUARD_EN
    vectors++; if (sp !== 4'd0 || err !== 1'b1 || err_ovf !== 1'b0) begin miscompares++; $display("FAIL unf_guard: got sp=%0d err=%b ovf=%b expected 0/1/0", sp, err, err_ovf); end
    apply(1, 0, 0, 1, 32'd3);
    vectors++; if (sp !== 4'd1 || rd1 !== 32'd3 || err !== 1'b1) begin miscompares++; $display("FAIL unf_sticky: got sp=%0d rd1=%0d err=%b expected 1/3/1", sp, rd1, err); end
`else
    vectors++; if (sp !== 4'd15 || err !== 1'b0) begin miscompares++; $display("FAIL unf_wrap: got sp=%0d err=%b expected 15/0", sp, err); end
    apply(1, 0, 0, 1, 32'd3);
    vectors++; if (sp !== 4'd0 || rd1 !== 32'd0) begin miscompares++; $display("FAIL unf_wrap_push: got sp=%0d rd1=%0d expected 0/0", sp, rd1); end
`endif
  endtask

  task automatic test_hold_and_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) apply(1, 0, 0, 1, 32'h100 + i);
    apply(0, 1, 1, 1, 32'hdead);
    vectors++; if (sp !== 4'd3 || rd1 !== 32'h102 || rd2 !== 32'h101) begin miscompares++; $display("FAIL hold: got sp=%0d rd1=%h rd2=%h expected 3/102/101", sp, rd1, rd2); end
    en = 1; write_reg = 1; wdata = 32'hbeef;
    #2;
    rst_n = 0;
    #1;
    m_sp = 0; m_err = 0; m_ovf = 0;
    vectors++; if (sp !== 4'd0 || empty !== 1'b1 || rd1 !== '0) begin miscompares++; $display("FAIL async_reset: got sp=%0d empty=%b rd1=%h expected 0/1/0", sp, empty, rd1); end
    @(posedge clk);
    #1;
    vectors++; if (sp !== 4'd0) begin miscompares++; $display("FAIL reset_discard: got sp=%0d expected 0", sp); end
    en = 0; write_reg = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      apply(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 2) != 0), $urandom);
      vectors++; if (sp !== 4'(m_sp)) begin miscompares++; $display("FAIL rnd_sp[%0d]: got %0d expected %0d", i, sp, m_sp); end
      vectors++; if (full !== (m_sp == D) || empty !== (m_sp == 0)) begin miscompares++; $display("FAIL rnd_flags[%0d]: got full=%b empty=%b sp_model=%0d", i, full, empty, m_sp); end
      vectors++; if (err !== m_err || err_ovf !== m_ovf) begin miscompares++; $display("FAIL rnd_err[%0d]: got %b/%b expected %b/%b", i, err, err_ovf, m_err, m_ovf); end
      if (m_sp < 1 || m_ok[wrap(m_sp - 1, D)]) begin
        e1 = (m_sp >= 1) ? m_mem[wrap(m_sp - 1, D)] : 32'd0;
        vectors++; if (rd1 !== e1) begin miscompares++; $display("FAIL rnd_rd1[%0d]: got %h expected %h", i, rd1, e1); end
      end
      if (m_sp < 2 || m_ok[wrap(m_sp - 2, D)]) begin
        e2 = (m_sp >= 2) ? m_mem[wrap(m_sp - 2, D)] : 32'd0;
        vectors++; if (rd2 !== e2) begin miscompares++; $display("FAIL rnd_rd2[%0d]: got %h expected %h", i, rd2, e2); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < D; i++) begin
      m_mem[i] = '0;
      m_ok[i] = 0;
    end
    m_sp = 0; m_err = 0; m_ovf = 0;
    test_reset();
    test_push_pair();
    test_pop_push();
    test_full_legal();
    test_overflow();
    test_underflow();
    test_hold_and_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
